// File: rtl/org_rd_sequencer.sv
// org_rd_sequencer: turns a level request from an upstream PIO into a run of
// single-word memory reads, streaming each returned word out on a valid/ready
// port. Exactly one read is outstanding at a time.
//
// Ports:
//   clk, reset_n        - clock, synchronous active-low reset
//   org_rd              - request level; a rising edge in IDLE starts a transfer
//   org_addr, org_len   - base word address and word count, latched at start
//   avm_*               - memory read master (address/read/waitrequest/readdata/readdatavalid)
//   dout, dout_valid,
//   dout_ready          - output word stream
//   busy                - transfer in progress
//   done                - transfer complete, held until org_rd drops
module org_rd_sequencer #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              org_rd,
  input  logic [ADDR_W-1:0] org_addr,
  input  logic [LEN_W-1:0]  org_len,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_PUSH = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               org_rd_prev_q, org_rd_prev_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               avm_read_q, avm_read_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state and next-output logic; outputs are decoded from the next state
  // so they are registered alongside it.
  always_comb begin
    state_d       = state_q;
    org_rd_prev_d = org_rd;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    dout_d        = dout_q;
    dout_valid_d  = dout_valid_q;

    case (state_q)
      S_IDLE: begin
        // Edge against the registered previous level: a request held high
        // through DONE cannot retrigger.
        if (org_rd && !org_rd_prev_q) begin
          addr_d      = org_addr;
          remaining_d = org_len;
          state_d     = (org_len == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (!avm_waitrequest) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (avm_readdatavalid) begin
          dout_d       = avm_readdata;
          dout_valid_d = 1'b1;
          state_d      = S_PUSH;
        end
      end
      S_PUSH: begin
        if (dout_ready) begin
          dout_valid_d = 1'b0;
          addr_d       = addr_q + ADDR_W'(1);
          remaining_d  = remaining_q - LEN_W'(1);
          state_d      = (remaining_q > LEN_W'(1)) ? S_REQ : S_DONE;
        end
      end
      S_DONE: begin
        if (!org_rd) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    avm_read_d = (state_d == S_REQ);
    busy_d     = (state_d == S_REQ) || (state_d == S_WAIT) || (state_d == S_PUSH);
    done_d     = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      org_rd_prev_q <= 1'b0;
      addr_q        <= '0;
      remaining_q   <= '0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      avm_read_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      org_rd_prev_q <= org_rd_prev_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      avm_read_q    <= avm_read_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = avm_read_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_org_rd_sequencer.sv
// Testbench for org_rd_sequencer: random and directed transfers against a
// memory model returning (truncated) address as data. Expected read addresses
// and output words are queued at request time and popped by a monitor.
module tb_org_rd_sequencer;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              org_rd;
  logic [ADDR_W-1:0] org_addr;
  logic [LEN_W-1:0]  org_len;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              busy;
  logic              done;

  org_rd_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .org_rd(org_rd), .org_addr(org_addr), .org_len(org_len),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
    return DATA_W'(a);
  endfunction

  // Scoreboard queues and environment knobs
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  bit mon_en         = 1'b0;
  int reads_accepted = 0;
  int words_out      = 0;
  int mem_lat        = 0;
  int stall_pct      = 0;
  int rdy_low_pct    = 0;
  int stall_read_idx = -1;
  int stall_left     = 0;
  int ready_hold_word = -1;
  int ready_left     = 0;

  // Memory model: one response per accepted read, mem_lat cycles later.
  bit                pend     = 1'b0;
  int                pend_cnt = 0;
  logic [ADDR_W-1:0] pend_addr = '0;
  initial begin
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
  end
  always @(posedge clk) begin
    avm_readdatavalid <= 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        avm_readdatavalid <= 1'b1;
        avm_readdata      <= mem_data(pend_addr);
        pend              <= 1'b0;
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
    if (avm_read && !avm_waitrequest) begin
      if (mem_lat == 0) begin
        avm_readdatavalid <= 1'b1;
        avm_readdata      <= mem_data(avm_address);
      end else begin
        pend      <= 1'b1;
        pend_cnt  <= mem_lat - 1;
        pend_addr <= avm_address;
      end
    end
  end

  // Waitrequest / ready drivers (negedge), with directed hold windows.
  initial begin
    avm_waitrequest = 1'b0;
    dout_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (avm_read && reads_accepted == stall_read_idx && stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest = ($urandom_range(0, 99) < stall_pct);
      end
      if (dout_valid && words_out == ready_hold_word && ready_left > 0) begin
        dout_ready = 1'b0;
        ready_left--;
      end else begin
        dout_ready = !($urandom_range(0, 99) < rdy_low_pct);
      end
    end
  end

  // Monitor: pops expectations on read acceptance and output transfer,
  // and checks that stalled outputs hold steady.
  logic              p_rd, p_wr, p_dv, p_rdy;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_dout;
  initial begin
    p_rd = 1'b0; p_wr = 1'b0; p_dv = 1'b0; p_rdy = 1'b0; p_addr = '0; p_dout = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) begin
        p_rd = 1'b0;
        p_dv = 1'b0;
      end else begin
        if (p_rd && p_wr)
          chk(avm_read && avm_address == p_addr, "avm_hold", {avm_read, avm_address}, {1'b1, p_addr});
        if (p_dv && !p_rdy)
          chk(dout_valid && dout == p_dout, "dout_hold", {dout_valid, dout}, {1'b1, p_dout});
        if (avm_read && !avm_waitrequest) begin
          chk(exp_addr_q.size() != 0, "read_expected", 64'(avm_address), 64'(exp_addr_q.size()));
          if (exp_addr_q.size() != 0) begin
            logic [ADDR_W-1:0] ea;
            ea = exp_addr_q.pop_front();
            chk(avm_address == ea, "avm_address", 64'(avm_address), 64'(ea));
          end
          reads_accepted++;
        end
        if (dout_valid && dout_ready) begin
          chk(exp_data_q.size() != 0, "dout_expected", 64'(dout), 64'(exp_data_q.size()));
          if (exp_data_q.size() != 0) begin
            logic [DATA_W-1:0] ed;
            ed = exp_data_q.pop_front();
            chk(dout == ed, "dout_data", 64'(dout), 64'(ed));
          end
          words_out++;
        end
        p_rd = avm_read; p_wr = avm_waitrequest; p_addr = avm_address;
        p_dv = dout_valid; p_rdy = dout_ready; p_dout = dout;
      end
    end
  end

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n);
    logic [ADDR_W-1:0] x;
    for (int i = 0; i < int'(n); i++) begin
      x = a + ADDR_W'(i);
      exp_addr_q.push_back(x);
      exp_data_q.push_back(mem_data(x));
    end
  endtask

  // Wait for done after the start edge; lat = cycles from start edge to done.
  task automatic finish_xfer(input int start_cyc, input int n, input bit drop_early,
                             input int hold, output int lat);
    bit timeout;
    bit bad;
    @(negedge clk);
    org_addr = ADDR_W'($urandom);
    org_len  = LEN_W'($urandom);
    if (drop_early) org_rd = 1'b0;
    timeout = 1'b1;
    lat = -1;
    for (int k = 0; k < 300 + n * 150; k++) begin
      #2;
      if (done) begin
        timeout = 1'b0;
        lat = cyc - start_cyc;
        break;
      end
      @(negedge clk);
    end
    chk(!timeout, "done_seen", 64'(done), 64'd1);
    chk(!busy, "busy_at_done", 64'(busy), 64'd0);
    chk(exp_addr_q.size() == 0 && exp_data_q.size() == 0, "all_words_seen",
        64'(exp_data_q.size()), 64'd0);
    if (org_rd) begin
      bad = 1'b0;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        #2;
        if (!done || busy || avm_read || dout_valid) bad = 1'b1;
      end
      chk(!bad, "done_held", {done, busy, avm_read, dout_valid}, 64'b1000);
      @(negedge clk);
      org_rd = 1'b0;
    end
    @(posedge clk);
    #1;
    chk(!done && !busy, "done_cleared", {done, busy}, 64'd0);
  endtask

  task automatic run_xfer(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] n,
                          input bit drop_early, input int hold, output int lat);
    int sc;
    @(negedge clk);
    org_addr = a;
    org_len  = n;
    org_rd   = 1'b1;
    sc = cyc + 1;
    push_exp(a, n);
    finish_xfer(sc, int'(n), drop_early, hold, lat);
  endtask

  task automatic check_reset_outputs(input string name);
    chk(!avm_read && avm_address == '0 && !dout_valid && dout == '0 && !busy && !done, name,
        {avm_read, avm_address, dout_valid, dout, busy, done}, 64'd0);
  endtask

  initial begin
    int lat;
    int sc;
    bit bad;
    reset_n = 1'b0; org_rd = 1'b0; org_addr = '0; org_len = '0;
    repeat (3) @(negedge clk);
    #2;
    chk(!avm_read, "rst_avm_read", 64'(avm_read), 64'd0);
    chk(avm_address == '0, "rst_avm_address", 64'(avm_address), 64'd0);
    chk(!dout_valid, "rst_dout_valid", 64'(dout_valid), 64'd0);
    chk(dout == '0, "rst_dout", 64'(dout), 64'd0);
    chk(!busy, "rst_busy", 64'(busy), 64'd0);
    chk(!done, "rst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;

    // Four words, zero wait: 3 cycles per word, done 12 cycles after start.
    run_xfer(20'h00100, 8'd4, 1'b0, 2, lat);
    chk(lat == 12, "latency_len4", 64'(lat), 64'd12);

    // Zero-length request: done immediately, no reads, no output.
    run_xfer(20'h12345, 8'd0, 1'b1, 0, lat);
    chk(lat == 0, "latency_len0", 64'(lat), 64'd0);

    // Stall the 2nd read 5 cycles and hold ready low 3 cycles on the 3rd word.
    mem_lat = 1;
    stall_read_idx = reads_accepted + 1; stall_left = 5;
    ready_hold_word = words_out + 2; ready_left = 3;
    run_xfer(20'h0A000, 8'd4, 1'b0, 1, lat);
    chk(lat == 12 + 4 + 5 + 3, "latency_stalled", 64'(lat), 64'd24);
    mem_lat = 0;

    // Request held 50 cycles past done, then low one cycle and raised again.
    run_xfer(20'h03000, 8'd3, 1'b0, 50, lat);
    run_xfer(20'h04000, 8'd2, 1'b0, 0, lat);
    chk(lat == 6, "restart_after_drop", 64'(lat), 64'd6);

    // Address wrap.
    run_xfer(20'hFFFFE, 8'd3, 1'b0, 0, lat);

    // Maximum length.
    run_xfer(20'h20000, 8'd255, 1'b0, 0, lat);
    chk(lat == 765, "latency_len255", 64'(lat), 64'd765);

    // Randomized transfers.
    for (int t = 0; t < 30; t++) begin
      logic [ADDR_W-1:0] a;
      mem_lat     = $urandom_range(0, 3);
      stall_pct   = $urandom_range(0, 40);
      rdy_low_pct = $urandom_range(0, 50);
      a = ADDR_W'($urandom);
      if ($urandom_range(0, 3) == 0) a = ADDR_W'(20'hFFFFF - $urandom_range(0, 3));
      run_xfer(a, LEN_W'($urandom_range(0, 8)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 4), lat);
    end
    stall_pct = 0; rdy_low_pct = 0;

    // Reset during WAIT of word 2 of 4; its response arrives after reset.
    mem_lat = 2;
    sc = reads_accepted;
    @(negedge clk);
    org_addr = 20'h05000; org_len = 8'd4; org_rd = 1'b1;
    push_exp(20'h05000, 8'd4);
    @(negedge clk);
    org_rd = 1'b0;
    bad = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #2;
      if (reads_accepted >= sc + 2) begin bad = 1'b0; break; end
      @(negedge clk);
    end
    chk(!bad, "second_read_reached", 64'(reads_accepted - sc), 64'd2);
    @(posedge clk);
    @(negedge clk);
    mon_en = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    #2;
    check_reset_outputs("reset_mid_xfer");
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #2;
      if (avm_read || dout_valid || busy || done) bad = 1'b1;
    end
    chk(!bad, "late_response_dropped", {avm_read, dout_valid, busy, done}, 64'd0);
    mon_en = 1'b1;
    mem_lat = 0;

    // Request already high when reset releases: starts on first cycle.
    @(negedge clk);
    mon_en = 1'b0;
    reset_n = 1'b0;
    org_rd = 1'b1; org_addr = 20'h06000; org_len = 8'd2;
    @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;
    push_exp(20'h06000, 8'd2);
    sc = cyc + 1;
    finish_xfer(sc, 2, 1'b0, 0, lat);
    chk(lat == 6, "start_out_of_reset", 64'(lat), 64'd6);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
